// File: rtl/johnson_phase_tracker.sv
// Decodes a Johnson counter bus into a phase index / one-hot phase, verifies each step is the
// legal successor, locks after a run of good steps, counts laps and latches corruption as a fault.
module johnson_phase_tracker #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LAP_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [N-1:0]             q_in,
  input  logic                     clear_fault,
  output logic [$clog2(2*N)-1:0]   phase_idx,
  output logic [2*N-1:0]           phase_onehot,
  output logic                     step,
  output logic [LAP_W-1:0]         lap_count,
  output logic                     locked,
  output logic                     fault
);

  localparam int unsigned IdxW  = $clog2(2 * N);
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StUnlocked, StLocked, StFault} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      q_prev_q;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              step_q, step_d;
  logic [LAP_W-1:0]  lap_q, lap_d;
  logic [GoodW-1:0]  good_q, good_d;

  logic [N-1:0]      succ;
  logic [CntW-1:0]   ones, trans;
  logic [IdxW-1:0]   in_idx;
  logic              in_legal, is_hold, is_adv;

  // A Johnson code has at most one transition between adjacent bits; the MSB picks which half.
  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < N; i++) ones = ones + CntW'(q_in[i]);
    for (int i = 0; i < N - 1; i++) trans = trans + CntW'(q_in[i] ^ q_in[i+1]);
    in_legal = (trans <= CntW'(1));
    in_idx   = q_in[N-1] ? IdxW'(ones - CntW'(1)) : (IdxW'(2 * N - 1) - IdxW'(ones));
    succ     = {~q_prev_q[0], q_prev_q[N-1:1]};
    is_hold  = in_legal && (q_in == q_prev_q);
    is_adv   = in_legal && (q_in == succ);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    lap_d   = lap_q;
    good_d  = good_q;
    if (enable) begin
      case (state_q)
        StUnlocked: begin
          if (is_adv) begin
            idx_d = in_idx;
            if (good_q == GoodW'(LOCK_CNT - 1)) begin
              state_d = StLocked;
              good_d  = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end else if (!is_hold) begin
            good_d = '0;
            if (in_legal) idx_d = in_idx;
          end
        end
        StLocked: begin
          if (is_adv) begin
            idx_d  = in_idx;
            step_d = 1'b1;
            if (in_idx == '0) lap_d = lap_q + LAP_W'(1);
          end else if (!is_hold) begin
            state_d = StFault;
          end
        end
        StFault: begin
          if (clear_fault) begin
            state_d = StUnlocked;
            good_d  = '0;
            if (in_legal) idx_d = in_idx;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StUnlocked;
      q_prev_q <= {1'b1, {(N - 1){1'b0}}};
      idx_q    <= '0;
      step_q   <= 1'b0;
      lap_q    <= '0;
      good_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      lap_q   <= lap_d;
      good_q  <= good_d;
      if (enable) q_prev_q <= q_in;
    end
  end

  assign phase_idx    = idx_q;
  assign phase_onehot = {{(2 * N - 1){1'b0}}, 1'b1} << idx_q;
  assign step         = step_q;
  assign lap_count    = lap_q;
  assign locked       = (state_q == StLocked);
  assign fault        = (state_q == StFault);

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Table-driven bench for johnson_phase_tracker (N=4): directed vectors plus async-reset sequence.
module tb_johnson_phase_tracker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] q_in = 4'b1000;
  logic       clear_fault = 1'b0;
  logic [2:0] phase_idx;
  logic [7:0] phase_onehot;
  logic       step;
  logic [7:0] lap_count;
  logic       locked;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [3:0] q;
    logic       clr;
    int         idx;
    int         stp;
    int         lap;
    int         lk;
    int         ft;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] jseq [8];

  johnson_phase_tracker #(.N(4), .LOCK_CNT(4), .LAP_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .q_in         (q_in),
    .clear_fault  (clear_fault),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .step         (step),
    .lap_count    (lap_count),
    .locked       (locked),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input int stp, input int lap,
                           input int lk, input int ft);
    check({tag, " phase_idx"}, int'(phase_idx), idx);
    check({tag, " phase_onehot"}, int'(phase_onehot), 1 << idx);
    check({tag, " step"}, int'(step), stp);
    check({tag, " lap_count"}, int'(lap_count), lap);
    check({tag, " locked"}, int'(locked), lk);
    check({tag, " fault"}, int'(fault), ft);
  endtask

  task automatic add(input logic en, input logic [3:0] q, input logic clr, input int idx,
                     input int stp, input int lap, input int lk, input int ft);
    vec_t v;
    v.en = en; v.q = q; v.clr = clr;
    v.idx = idx; v.stp = stp; v.lap = lap; v.lk = lk; v.ft = ft;
    vecs.push_back(v);
  endtask

  initial begin
    int lap;
    int p;
    jseq[0] = 4'b1000; jseq[1] = 4'b1100; jseq[2] = 4'b1110; jseq[3] = 4'b1111;
    jseq[4] = 4'b0111; jseq[5] = 4'b0011; jseq[6] = 4'b0001; jseq[7] = 4'b0000;

    // Clean start: four ADVs lock, the fifth steps to idx 5
    add(1, 4'b1100, 0, 1, 0, 0, 0, 0);
    add(1, 4'b1110, 0, 2, 0, 0, 0, 0);
    add(1, 4'b1111, 0, 3, 0, 0, 0, 0);
    add(1, 4'b0111, 0, 4, 0, 0, 1, 0);
    add(1, 4'b0011, 0, 5, 1, 0, 1, 0);
    // Sixteen locked steps, two wraps
    lap = 0;
    for (int i = 0; i < 16; i++) begin
      p = (6 + i) % 8;
      if (p == 0) lap++;
      add(1, jseq[p], 0, p, 1, lap, 1, 0);
    end
    // Enable gating and repeated HOLD
    add(0, 4'b0001, 0, 5, 0, 2, 1, 0);
    add(0, 4'b1010, 0, 5, 0, 2, 1, 0);
    add(1, 4'b0011, 0, 5, 0, 2, 1, 0);
    add(1, 4'b0011, 0, 5, 0, 2, 1, 0);
    add(1, 4'b0001, 0, 6, 1, 2, 1, 0);
    add(0, 4'b0000, 0, 6, 0, 2, 1, 0);
    // Illegal code while locked, then clear and relock
    add(1, 4'b1010, 0, 6, 0, 2, 0, 1);
    add(1, 4'b0000, 0, 6, 0, 2, 0, 1);
    add(1, 4'b0000, 1, 7, 0, 2, 0, 0);
    add(1, 4'b1000, 0, 0, 0, 2, 0, 0);
    add(1, 4'b1100, 0, 1, 0, 2, 0, 0);
    add(1, 4'b1110, 0, 2, 0, 2, 0, 0);
    add(1, 4'b1111, 0, 3, 0, 2, 1, 0);
    add(1, 4'b0111, 1, 4, 1, 2, 1, 0);
    add(1, 4'b0011, 0, 5, 1, 2, 1, 0);
    add(1, 4'b0001, 0, 6, 1, 2, 1, 0);
    add(1, 4'b0000, 0, 7, 1, 2, 1, 0);
    add(1, 4'b1000, 0, 0, 1, 3, 1, 0);
    add(1, 4'b1100, 0, 1, 1, 3, 1, 0);
    // Legal code, wrong successor
    add(1, 4'b1111, 0, 1, 0, 3, 0, 1);
    // Unlocked BAD handling: legal jump reloads idx, illegal code does not
    add(1, 4'b1110, 1, 2, 0, 3, 0, 0);
    add(1, 4'b0011, 0, 5, 0, 3, 0, 0);
    add(1, 4'b1001, 0, 5, 0, 3, 0, 0);
    add(1, 4'b1001, 0, 5, 0, 3, 0, 0);
    add(1, 4'b1000, 0, 0, 0, 3, 0, 0);
    // Three ADVs, a BAD resets the run, then four fresh ADVs lock
    add(1, 4'b1100, 0, 1, 0, 3, 0, 0);
    add(1, 4'b1110, 0, 2, 0, 3, 0, 0);
    add(1, 4'b1111, 0, 3, 0, 3, 0, 0);
    add(1, 4'b1010, 0, 3, 0, 3, 0, 0);
    add(1, 4'b1111, 0, 3, 0, 3, 0, 0);
    add(1, 4'b0111, 0, 4, 0, 3, 0, 0);
    add(1, 4'b0011, 0, 5, 0, 3, 0, 0);
    add(1, 4'b0001, 0, 6, 0, 3, 0, 0);
    add(1, 4'b0000, 0, 7, 0, 3, 1, 0);

    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      enable      = vecs[i].en;
      q_in        = vecs[i].q;
      clear_fault = vecs[i].clr;
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].stp, vecs[i].lap,
                vecs[i].lk, vecs[i].ft);
    end

    // Async reset mid-lap while step is high
    @(negedge clock);
    enable = 1'b1; q_in = 4'b1000; clear_fault = 1'b0;
    @(posedge clock);
    #1;
    check_all("wrap_before_reset", 0, 1, 4, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clock);
    enable = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_all("post_reset_hold", 0, 0, 0, 0, 0);
    // Restart from the reset q_prev (1000): 1100 must be an ADV
    @(negedge clock);
    enable = 1'b1; q_in = 4'b1100;
    @(posedge clock);
    #1;
    check_all("post_reset_adv", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
